// File: rtl/imem_loader.sv
// imem_loader: serial boot loader feeding the IMEM write port.
// Receives a program image over UART 8N1 and writes 32-bit words into IMEM while
// holding the CPU in reset, so fetch never sees a half-written image.
// Frame: CNT_LO, CNT_HI (word count N), N little-endian words, [checksum byte].
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
// Ports:
//   clk_i        system clock
//   reset_i      asynchronous reset, active-low
//   rx_i         UART receive line (idle high, asynchronous)
//   imem_we_o    IMEM write strobe, one-cycle pulse per word
//   imem_addr_o  IMEM word address
//   imem_wdata_o IMEM write data
//   cpu_hold_o   1 = hold the CPU in reset
//   busy_o       1 = frame in progress
//   done_o       one-cycle pulse on error-free frame completion
//   err_o        sticky error (framing, timeout, overflow, checksum)
module imem_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned IMEM_AWIDTH  = 10,
  parameter int unsigned TIMEOUT_BITS = 64
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   rx_i,
  output logic                   imem_we_o,
  output logic [IMEM_AWIDTH-1:0] imem_addr_o,
  output logic [31:0]            imem_wdata_o,
  output logic                   cpu_hold_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF_BIT  = CLKS_PER_BIT / 2;
  localparam int unsigned TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TO_W      = $clog2(TO_CYCLES);
  localparam int unsigned DEPTH     = 2 ** IMEM_AWIDTH;

  // ---------------------------------------------------------------- UART RX
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

  rxState_t         rxState, rxStateD;
  logic             rxMeta, rxSync, rxSyncQ;
  logic [CNT_W-1:0] clkCnt, clkCntD;
  logic [2:0]       bitCnt, bitCntD;
  logic [7:0]       rxByte, rxByteD;
  logic             byteValid, byteValidD;
  logic             frameErr, frameErrD;

  // Synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rxMeta  <= 1'b0;
      rxSync  <= 1'b0;
      rxSyncQ <= 1'b0;
    end else begin
      rxMeta  <= rx_i;
      rxSync  <= rxMeta;
      rxSyncQ <= rxSync;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rxState   <= RX_IDLE;
      clkCnt    <= '0;
      bitCnt    <= '0;
      rxByte    <= '0;
      byteValid <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      rxState   <= rxStateD;
      clkCnt    <= clkCntD;
      bitCnt    <= bitCntD;
      rxByte    <= rxByteD;
      byteValid <= byteValidD;
      frameErr  <= frameErrD;
    end
  end

  // Receiver next state: start-bit recheck at half bit, then mid-bit samples.
  always_comb begin
    rxStateD   = rxState;
    clkCntD    = clkCnt;
    bitCntD    = bitCnt;
    rxByteD    = rxByte;
    byteValidD = 1'b0;
    frameErrD  = 1'b0;
    case (rxState)
      RX_IDLE: begin
        if (rxSyncQ && !rxSync) begin
          rxStateD = RX_START;
          clkCntD  = '0;
        end
      end
      RX_START: begin
        if (clkCnt == CNT_W'(HALF_BIT - 1)) begin
          clkCntD  = '0;
          bitCntD  = '0;
          rxStateD = rxSync ? RX_IDLE : RX_DATA;
        end else begin
          clkCntD = clkCnt + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (clkCnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          clkCntD = '0;
          rxByteD = {rxSync, rxByte[7:1]};
          if (bitCnt == 3'd7) rxStateD = RX_STOP;
          else                bitCntD  = bitCnt + 3'd1;
        end else begin
          clkCntD = clkCnt + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (clkCnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          clkCntD    = '0;
          byteValidD = rxSync;
          frameErrD  = !rxSync;
          rxStateD   = RX_IDLE;
        end else begin
          clkCntD = clkCnt + CNT_W'(1);
        end
      end
      default: rxStateD = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- Frame FSM
`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_CNT_HI, S_DATA, S_CHK, S_DONE} state_t;
  localparam state_t S_END = S_CHK;
`else
  typedef enum logic [2:0] {S_IDLE, S_CNT_HI, S_DATA, S_DONE} state_t;
  localparam state_t S_END = S_DONE;
`endif

  state_t                 state, stateD;
  logic [7:0]             cntLo, cntLoD;
  logic [15:0]            wordCount, wordCountD;
  logic [1:0]             byteIdx, byteIdxD;
  logic [23:0]            wordReg, wordRegD;
  logic [15:0]            wordIdx, wordIdxD;
  logic [TO_W-1:0]        toCnt, toCntD;
  logic                   weD, holdD, busyD, doneD, errD;
  logic [IMEM_AWIDTH-1:0] addrD;
  logic [31:0]            wdataD;
  logic                   inFrame;
  logic                   timeout;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]             chkSum, chkSumD;
`endif

  // Frame state and registered outputs.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state        <= S_IDLE;
      cntLo        <= '0;
      wordCount    <= '0;
      byteIdx      <= '0;
      wordReg      <= '0;
      wordIdx      <= '0;
      toCnt        <= '0;
      imem_we_o    <= 1'b0;
      imem_addr_o  <= '0;
      imem_wdata_o <= '0;
      cpu_hold_o   <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chkSum       <= '0;
`endif
    end else begin
      state        <= stateD;
      cntLo        <= cntLoD;
      wordCount    <= wordCountD;
      byteIdx      <= byteIdxD;
      wordReg      <= wordRegD;
      wordIdx      <= wordIdxD;
      toCnt        <= toCntD;
      imem_we_o    <= weD;
      imem_addr_o  <= addrD;
      imem_wdata_o <= wdataD;
      cpu_hold_o   <= holdD;
      busy_o       <= busyD;
      done_o       <= doneD;
      err_o        <= errD;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chkSum       <= chkSumD;
`endif
    end
  end

  // Inter-byte watchdog only runs while a frame is being received.
  assign inFrame = (state != S_IDLE) && (state != S_DONE);
  assign timeout = inFrame && !byteValid && (toCnt == TO_W'(TO_CYCLES - 1));

  // Frame next state and output values.
  always_comb begin
    stateD     = state;
    cntLoD     = cntLo;
    wordCountD = wordCount;
    byteIdxD   = byteIdx;
    wordRegD   = wordReg;
    wordIdxD   = wordIdx;
    toCntD     = (inFrame && !byteValid) ? toCnt + TO_W'(1) : '0;
    weD        = 1'b0;
    addrD      = imem_addr_o;
    wdataD     = imem_wdata_o;
    holdD      = cpu_hold_o;
    busyD      = busy_o;
    doneD      = 1'b0;
    errD       = err_o;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chkSumD    = (byteValid && state != S_CHK) ? (chkSum ^ rxByte) : chkSum;
`endif
    case (state)
      S_IDLE: begin
        if (byteValid) begin
          cntLoD = rxByte;
          holdD  = 1'b1;
          busyD  = 1'b1;
          errD   = 1'b0;
          stateD = S_CNT_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chkSumD = rxByte;
`endif
        end
      end
      S_CNT_HI: begin
        if (byteValid) begin
          wordCountD = {rxByte, cntLo};
          wordIdxD   = '0;
          byteIdxD   = '0;
          stateD     = ({rxByte, cntLo} == 16'd0) ? S_END : S_DATA;
        end
      end
      S_DATA: begin
        if (byteValid) begin
          wordRegD = {rxByte, wordReg[23:8]};
          byteIdxD = byteIdx + 2'd1;
          if (byteIdx == 2'd3) begin
            // Words past the IMEM depth are consumed but never written.
            if (32'(wordIdx) < DEPTH) begin
              weD    = 1'b1;
              addrD  = IMEM_AWIDTH'(wordIdx);
              wdataD = {rxByte, wordReg};
            end else begin
              errD = 1'b1;
            end
            wordIdxD = wordIdx + 16'd1;
            if (wordIdx == wordCount - 16'd1) stateD = S_END;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (byteValid) begin
          if (rxByte != chkSum) errD = 1'b1;
          stateD = S_DONE;
        end
      end
`endif
      S_DONE: begin
        holdD  = 1'b0;
        busyD  = 1'b0;
        stateD = S_IDLE;
      end
      default: stateD = S_IDLE;
    endcase

    // Framing error or timeout: flag it and abort any frame in progress.
    if (frameErr || timeout) begin
      errD = 1'b1;
      if (inFrame) begin
        stateD = S_IDLE;
        holdD  = 1'b0;
        busyD  = 1'b0;
      end
    end

    if (stateD == S_DONE && state != S_DONE) doneD = !errD;
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int CPB = 16;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          imem_we_o;
  logic [AW-1:0] imem_addr_o;
  logic [31:0]   imem_wdata_o;
  logic          cpu_hold_o, busy_o, done_o, err_o;

  always #5 clk = ~clk;

  imem_loader #(.CLKS_PER_BIT(CPB), .IMEM_AWIDTH(AW), .TIMEOUT_BITS(64)) dut (
    .clk_i(clk), .reset_i(rst_n), .rx_i(rx),
    .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o),
    .cpu_hold_o(cpu_hold_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  typedef struct packed {logic [AW-1:0] addr; logic [31:0] data;} wr_t;

  wr_t        expQ[$];
  wr_t        got;
  int         checks = 0;
  int         errors = 0;
  int         doneCnt = 0;
  int         doneBase;
  bit         prevDone = 1'b0;
  logic [7:0] sum;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected writes, counts done pulses, checks hold release.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prevDone) check("hold_released_after_done", 32'(cpu_hold_o), 32'd0);
      if (done_o) begin
        doneCnt++;
        check("hold_during_done", 32'(cpu_hold_o), 32'd1);
      end
      prevDone = done_o;
      if (imem_we_o) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual addr=%h data=%h required=no write", imem_addr_o, imem_wdata_o);
        end else begin
          got = expQ.pop_front();
          check("wr_addr", 32'(imem_addr_o), 32'(got.addr));
          check("wr_data", imem_wdata_o, got.data);
        end
      end
    end
  end

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stopBit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (!stopBit) repeat (CPB) @(negedge clk);
  endtask

  task automatic sendB(input logic [7:0] b);
    sum = sum ^ b;
    sendByte(b, 1'b1);
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int i = 0; i < 4; i++) sendB(w[8*i +: 8]);
  endtask

  // Checksum byte exists only when the feature is built in.
  task automatic sendChk(input bit good);
`ifdef IMEM_LOADER_CHECKSUM_EN
    sendByte(good ? sum : ~sum, 1'b1);
`else
    if (!good) sendByte(8'h00, 1'b1);
`endif
  endtask

  task automatic pushWr(input int a, input logic [31:0] d);
    wr_t e;
    e.addr = AW'(a);
    e.data = d;
    expQ.push_back(e);
  endtask

  task automatic checkEnd(input string tag, input int expDone, input logic expErr);
    repeat (20) @(negedge clk);
    check({tag, "_done_count"}, 32'(doneCnt), 32'(expDone));
    check({tag, "_hold"}, 32'(cpu_hold_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_err"}, 32'(err_o), 32'(expErr));
    check({tag, "_writes_pending"}, 32'(expQ.size()), 32'd0);
  endtask

  logic [31:0] w;

  initial begin
    repeat (5) @(negedge clk);
    check("rst_we", 32'(imem_we_o), 32'd0);
    check("rst_addr", 32'(imem_addr_o), 32'd0);
    check("rst_wdata", imem_wdata_o, 32'd0);
    check("rst_hold", 32'(cpu_hold_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic two-word load.
    doneBase = doneCnt;
    sum = 8'h00;
    sendB(8'h02);
    repeat (4) @(negedge clk);
    check("load2_hold_after_cntlo", 32'(cpu_hold_o), 32'd1);
    check("load2_busy_after_cntlo", 32'(busy_o), 32'd1);
    sendB(8'h00);
    pushWr(0, 32'h0050_0093);
    pushWr(1, 32'h00A0_0113);
    sendWord(32'h0050_0093);
    sendWord(32'h00A0_0113);
    sendChk(1'b1);
    checkEnd("load2", doneBase + 1, 1'b0);

    // Empty frame.
    doneBase = doneCnt;
    sum = 8'h00;
    sendB(8'h00);
    sendB(8'h00);
    sendChk(1'b1);
    checkEnd("n0", doneBase + 1, 1'b0);

    // Framing error during DATA.
    doneBase = doneCnt;
    sum = 8'h00;
    sendB(8'h01);
    sendB(8'h00);
    sendByte(8'h00, 1'b0);
    checkEnd("framing", doneBase, 1'b1);

    // Timeout: N=3 but only one word arrives.
    doneBase = doneCnt;
    sum = 8'h00;
    sendB(8'h03);
    sendB(8'h00);
    pushWr(0, 32'h1122_3344);
    sendWord(32'h1122_3344);
    repeat (500) @(negedge clk);
    check("timeout_hold_before", 32'(cpu_hold_o), 32'd1);
    check("timeout_busy_before", 32'(busy_o), 32'd1);
    repeat (600) @(negedge clk);
    checkEnd("timeout", doneBase, 1'b1);

    // Recovery frame clears the sticky error on its first byte.
    doneBase = doneCnt;
    sum = 8'h00;
    sendB(8'h01);
    repeat (4) @(negedge clk);
    check("recover_err_cleared", 32'(err_o), 32'd0);
    sendB(8'h00);
    pushWr(0, 32'hDEAD_BEEF);
    sendWord(32'hDEAD_BEEF);
    sendChk(1'b1);
    checkEnd("recover", doneBase + 1, 1'b0);

    // Overflow: 17 words into a 16-word IMEM.
    doneBase = doneCnt;
    sum = 8'h00;
    sendB(8'h11);
    sendB(8'h00);
    for (int i = 0; i < 17; i++) begin
      w = {8'hA5, 8'(i), 8'h5A, 8'(i * 3)};
      if (i < 16) pushWr(i, w);
      sendWord(w);
    end
    sendChk(1'b1);
    checkEnd("overflow", doneBase, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum: word written, no done, hold still released.
    doneBase = doneCnt;
    sum = 8'h00;
    sendB(8'h01);
    sendB(8'h00);
    pushWr(0, 32'h0000_0013);
    sendWord(32'h0000_0013);
    sendChk(1'b0);
    checkEnd("badchk", doneBase, 1'b1);
`endif

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
